// File: rtl/neural_soc_nios2_gen2_0_cpu_debug_pkg.sv
// Shared types and constants for the debug-slave virtual-JTAG initiator.
package neural_soc_nios2_gen2_0_cpu_debug_pkg;
  localparam int DEF_DR_WIDTH = 38;

  localparam logic [1:0] OCIMEM    = 2'b00;
  localparam logic [1:0] TRACEMEM  = 2'b01;
  localparam logic [1:0] BREAK     = 2'b10;
  localparam logic [1:0] TRACECTRL = 2'b11;

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RESP} state_t;
endpackage

// File: rtl/neural_soc_nios2_gen2_0_cpu_debug_scan_tck_gen.sv
// TCK generator: TCK_DIV cycles low then TCK_DIV cycles high per period, held low when disabled.
module neural_soc_nios2_gen2_0_cpu_debug_scan_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic period_start,
  output logic tck_rise,
  output logic period_end
);
  logic [7:0] cnt;
  logic       last;

  assign last         = (cnt == 8'(TCK_DIV - 1));
  assign period_start = en && !tck && (cnt == 8'd0);
  assign tck_rise     = en && !tck && last;
  assign period_end   = en && tck && last;

  // tck doubles as the half-period phase, so it is glitch-free even at TCK_DIV=1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (last) begin
      cnt <= '0;
      tck <= !tck;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: rtl/neural_soc_nios2_gen2_0_cpu_debug_scan_master.sv
// Virtual-JTAG initiator: runs one IR update plus a full DR capture/shift/update per command.
module neural_soc_nios2_gen2_0_cpu_debug_scan_master
  import neural_soc_nios2_gen2_0_cpu_debug_pkg::*;
#(
  parameter int DR_WIDTH = DEF_DR_WIDTH,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic                busy
);
  localparam int CW = $clog2(DR_WIDTH + 1);

  state_t              state;
  logic [DR_WIDTH-1:0] shift_reg;
  logic [IR_WIDTH-1:0] ir_lat;
  logic [CW-1:0]       bit_cnt;
  logic                tdo_smp;
  logic                scan_en, period_start, tck_rise, period_end;

  assign scan_en = (state == UIR) || (state == CDR) || (state == SDR) || (state == UDR);
  assign busy    = (state != IDLE);

  neural_soc_nios2_gen2_0_cpu_debug_scan_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (scan_en),
    .tck          (vji_tck),
    .period_start (period_start),
    .tck_rise     (tck_rise),
    .period_end   (period_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dr    <= '0;
      vji_tdi   <= 1'b0;
      vji_ir_in <= '0;
      vji_uir   <= 1'b0;
      vji_cdr   <= 1'b0;
      vji_sdr   <= 1'b0;
      vji_udr   <= 1'b0;
      vji_rti   <= 1'b1;
      shift_reg <= '0;
      ir_lat    <= '0;
      bit_cnt   <= '0;
      tdo_smp   <= 1'b0;
    end else begin
      if (state == SDR && tck_rise) tdo_smp <= vji_tdo;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= UIR;
            cmd_ready <= 1'b0;
            ir_lat    <= cmd_ir;
            shift_reg <= cmd_dr;
            vji_rti   <= 1'b0;
            vji_uir   <= 1'b1;
          end else begin
            cmd_ready <= !rsp_valid;
          end
        end
        UIR: begin
          if (period_start) vji_ir_in <= ir_lat;
          if (period_end) begin
            state   <= CDR;
            vji_uir <= 1'b0;
            vji_cdr <= 1'b1;
          end
        end
        CDR: begin
          if (period_end) begin
            state   <= SDR;
            vji_cdr <= 1'b0;
            vji_sdr <= 1'b1;
            bit_cnt <= '0;
            vji_tdi <= shift_reg[0];
          end
        end
        SDR: begin
          // TDO enters at the MSB so the first bit captured ends up in bit 0
          if (period_end) begin
            shift_reg <= {tdo_smp, shift_reg[DR_WIDTH-1:1]};
            bit_cnt   <= (bit_cnt == CW'(DR_WIDTH)) ? bit_cnt : bit_cnt + 1'b1;
            if (bit_cnt == CW'(DR_WIDTH - 1)) begin
              state   <= UDR;
              vji_sdr <= 1'b0;
              vji_udr <= 1'b1;
              vji_tdi <= 1'b0;
            end else begin
              vji_tdi <= shift_reg[1];
            end
          end
        end
        UDR: begin
          if (period_end) begin
            state     <= RESP;
            vji_udr   <= 1'b0;
            vji_rti   <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_dr    <= shift_reg;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neural_soc_nios2_gen2_0_cpu_debug_scan_master.sv
// Directed bench for the debug scan master: defaults plus a TCK_DIV=1 instance.
module tb_neural_soc_nios2_gen2_0_cpu_debug_scan_master;
  import neural_soc_nios2_gen2_0_cpu_debug_pkg::*;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_valid1 = 1'b0, rsp_ready = 1'b0, tdo_tie = 1'b0;
  logic [1:0]  cmd_ir = '0;
  logic [37:0] cmd_dr = '0;

  logic        cmd_ready, rsp_valid, tck, tdi, tdo, uir, cdr, sdr, udr, rti, busy;
  logic [37:0] rsp_dr;
  logic [1:0]  ir_in;
  logic        cmd_ready1, rsp_valid1, tck1, tdi1, uir1, cdr1, sdr1, udr1, rti1, busy1;
  logic [37:0] rsp_dr1;
  logic [1:0]  ir_in1;

  int n_cmp = 0, n_err = 0;
  int rise_cnt = 0, tdi_seen = 0, hot_bad = 0, tdi1_cnt = 0, tdi1_bad = 0, tog_bad = 0;
  logic [1:0] ir_udr = '0;
  logic prev_tck1 = 1'b0, prev_scan1 = 1'b0;

  assign tdo = tdo_tie ? 1'b1 : tdi;

  always #5 clk = ~clk;

  neural_soc_nios2_gen2_0_cpu_debug_scan_master dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dr(rsp_dr), .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo), .vji_ir_in(ir_in),
    .vji_uir(uir), .vji_cdr(cdr), .vji_sdr(sdr), .vji_udr(udr), .vji_rti(rti), .busy(busy));

  neural_soc_nios2_gen2_0_cpu_debug_scan_master #(.TCK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_dr(rsp_dr1), .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdi1), .vji_ir_in(ir_in1),
    .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1), .busy(busy1));

  always @(posedge tck) if (sdr) rise_cnt++;

  always @(negedge clk) begin
    if (tdi) tdi_seen++;
    if (udr) ir_udr = ir_in;
    if ($countones({uir, cdr, sdr, udr, rti}) != 1) hot_bad++;
    if (tdi1) begin
      tdi1_cnt++;
      if (!sdr1) tdi1_bad++;
    end
    if ((uir1 | cdr1 | sdr1 | udr1) && prev_scan1 && (tck1 == prev_tck1)) tog_bad++;
    prev_scan1 = uir1 | cdr1 | sdr1 | udr1;
    prev_tck1  = tck1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; lat is the cycle (accept edge = 0) in which rsp_valid is first high.
  task automatic scan(input logic [1:0] ir, input logic [37:0] dr, input bit hold, output int lat);
    cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    chk("cmd_ready_pre_accept", cmd_ready, 1);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 2000) begin @(negedge clk); lat++; end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    bit stable, seen;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_outputs", {rsp_valid, busy, tck, tdi, uir, cdr, sdr, udr, rti}, 9'b000000001);
    chk("rst_rsp_dr", rsp_dr, 0);
    chk("rst_ir_in", ir_in, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_release", cmd_ready, 1);

    // loopback
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_ready_no_valid", {rsp_valid, busy}, 2'b00);
    scan(BREAK, 38'h2A_5555_AAAA, 1'b0, lat);
    chk("loop_latency", lat, 329);
    chk("loop_rsp_dr", rsp_dr, 38'h2A_5555_AAAA);
    chk("loop_ir_in_udr", ir_udr, 2'b10);
    handshake();

    // tdo tied high, held response, back-to-back command
    tdo_tie = 1'b1; tdi_seen = 0; rise_cnt = 0;
    scan(TRACEMEM, 38'h0, 1'b1, lat);
    chk("ones_latency", lat, 329);
    chk("ones_rsp_dr", rsp_dr, 38'h3F_FFFF_FFFF);
    chk("ones_tdi_zero", tdi_seen, 0);
    chk("ones_sdr_rises", rise_cnt, 38);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_dr !== 38'h3F_FFFF_FFFF || cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || uir !== 1'b0) stable = 1'b0;
    end
    chk("held_rsp_stable", stable, 1);
    handshake();
    chk("post_hs_valid_ready", {rsp_valid, cmd_ready}, 2'b00);
    @(negedge clk);
    chk("post_hs_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("second_accept", {busy, uir, cmd_ready}, 3'b110);
    lat = 0;
    while (!rsp_valid && lat < 2000) begin @(negedge clk); lat++; end
    chk("second_rsp_dr", rsp_dr, 38'h3F_FFFF_FFFF);
    handshake();
    tdo_tie = 1'b0;

    // TCK_DIV = 1 instance, loopback
    tdi1_cnt = 0; tdi1_bad = 0; tog_bad = 0;
    cmd_ir = OCIMEM; cmd_dr = 38'h1; cmd_valid1 = 1'b1;
    chk("div1_ready", cmd_ready1, 1);
    @(negedge clk);
    cmd_valid1 = 1'b0;
    lat = 1;
    while (!rsp_valid1 && lat < 2000) begin @(negedge clk); lat++; end
    chk("div1_latency", lat, 83);
    chk("div1_rsp_dr", rsp_dr1, 38'h1);
    chk("div1_tdi_cycles", tdi1_cnt, 2);
    chk("div1_tdi_outside_sdr", tdi1_bad, 0);
    chk("div1_tck_toggle", tog_bad, 0);
    handshake();

    // reset in the 20th SDR bit
    rise_cnt = 0;
    cmd_ir = TRACECTRL; cmd_dr = 38'h15_0F0F_3C3C; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 1000 && rise_cnt < 20; i++) @(negedge clk);
    chk("mid_reset_reached", {rise_cnt[7:0], sdr}, {8'd20, 1'b1});
    reset_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {cmd_ready, rsp_valid, busy, tck, tdi, uir, cdr, sdr, udr, rti}, 10'b0000000001);
    chk("mid_reset_data", {rsp_dr, ir_in}, 40'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    chk("mid_reset_no_rsp", seen, 0);
    scan(TRACECTRL, 38'h15_0F0F_3C3C, 1'b0, lat);
    chk("after_reset_latency", lat, 329);
    chk("after_reset_rsp_dr", rsp_dr, 38'h15_0F0F_3C3C);
    handshake();
    chk("strobe_one_hot", hot_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/neural_soc_nios2_gen2_0_cpu_debug_scan_master.md
Name: neural_soc_nios2_gen2_0_cpu_debug_scan_master

Overview:
- Initiator end of the virtual-JTAG debug-slave interface: drives TCK, TDI, IR value and virtual-state strobes (uir/cdr/sdr/udr/rti), and samples TDO.
- Converts a sysclk command (IR code plus 38-bit DR payload) into one full IR-update + DR capture/shift/update sequence, then returns the 38-bit captured DR.
- Used for on-chip self-test and for simulation benches that exercise the debug slave without a physical JTAG hub.

Parameters:
- DR_WIDTH, 38, bits shifted per DR scan.
- IR_WIDTH, 2, width of the virtual IR.
- TCK_DIV, 4, clk cycles per TCK half-period; legal range 1..255.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_ir  in  IR_WIDTH  IR value for this scan.
- cmd_dr  in  DR_WIDTH  DR data to shift out, LSB first.
- rsp_valid  out  1  captured DR is available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_dr  out  DR_WIDTH  DR bits captured from vji_tdo.
- vji_tck  out  1  generated TCK.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_WIDTH  virtual IR value.
- vji_uir, vji_cdr, vji_sdr, vji_udr  out  1 each  virtual-state strobes.
- vji_rti  out  1  run-test-idle indicator.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n; every flop clears immediately when it asserts.
- Reset values:
  - cmd_ready=0, rsp_valid=0, rsp_dr=0, busy=0.
  - vji_tck=0, vji_tdi=0, vji_ir_in=0.
  - vji_uir/cdr/sdr/udr=0, vji_rti=1.
  - cmd_ready rises on the first clk edge after reset release.
- States: IDLE -> UIR -> CDR -> SDR -> UDR -> RESP -> IDLE.
- Each of UIR, CDR, UDR and each SDR bit occupies exactly one TCK period (2*TCK_DIV clk cycles).
- TCK timing: TCK is low for the first TCK_DIV cycles of a period and high for the second TCK_DIV cycles. TCK is registered, and idles low outside UIR..UDR.
- Strobes: exactly one of uir/cdr/sdr/udr/rti is high at any time. The active strobe is high for the whole period of its state; rti is high in IDLE and RESP.
- IDLE:
  - cmd_ready = !rsp_valid.
  - On accept, latch cmd_ir and cmd_dr into the shift register, go to UIR, and clear cmd_ready the same edge.
- UIR: vji_ir_in is loaded with the latched IR at the start of the period and held until the next command's UIR (it persists through IDLE).
- CDR: one period, then SDR with bit count = 0.
- SDR:
  - vji_tdi = shift_reg[0]; it changes only at the start of a period, while TCK is low.
  - vji_tdo is sampled on the clk edge on which TCK rises.
  - At the end of each period: shift right, sampled TDO enters the MSB, increment count.
  - After DR_WIDTH periods, go to UDR.
  - Result ordering: the first TDO bit sampled lands in rsp_dr[0].
- UDR: one period, then RESP. rsp_dr is loaded with the shift register, and rsp_valid rises on the final edge of UDR.
- RESP: rsp_valid and rsp_dr are held stable until rsp_ready. On handshake, rsp_valid clears and the state returns to IDLE; cmd_ready rises on the following edge.
- Latency: with the accept edge counted as cycle 0, rsp_valid is first high in cycle (DR_WIDTH+3)*2*TCK_DIV + 1. For defaults this is cycle 329.
- Boundaries:
  - cmd_valid while busy is ignored, because cmd_ready is 0.
  - rsp_ready without rsp_valid is ignored.
  - The bit counter saturates at DR_WIDTH.
  - TCK_DIV=1 gives TCK = clk/2, with no glitch between periods.
- Reset mid-operation: the scan is abandoned, all outputs return to reset values, and no response is produced.

Decomposition:
- Shared package neural_soc_nios2_gen2_0_cpu_debug_pkg, containing:
  - state enum (IDLE, UIR, CDR, SDR, UDR, RESP);
  - IR code constants: OCIMEM=2'b00, TRACEMEM=2'b01, BREAK=2'b10, TRACECTRL=2'b11;
  - DR_WIDTH default.
- One sub-module, neural_soc_nios2_gen2_0_cpu_debug_scan_tck_gen: half-period counter that produces registered TCK plus one-cycle period_start, tck_rise and period_end pulses.

Test Plan:
- Reset -> cmd_ready=0 during reset and 1 the cycle after release; rti=1; tck=0; all other strobes 0.
- Loopback (tdo=tdi), cmd_ir=2'b10, cmd_dr=38'h2A_5555_AAAA -> rsp_dr=38'h2A_5555_AAAA; ir_in=2'b10 during UDR; rsp_valid first high in cycle 329.
- vji_tdo tied 1, cmd_dr=0 -> rsp_dr=38'h3F_FFFF_FFFF; tdi stays 0 throughout; exactly 38 TCK rising edges while sdr=1.
- rsp_ready held low for 10 cycles after rsp_valid, with cmd_valid high -> rsp_dr stable, cmd_ready=0, no second scan; after the handshake, the next command is accepted one cycle later.
- TCK_DIV=1, loopback, cmd_dr=38'h1 -> tck toggles every clk; tdi=1 only during the first SDR period; rsp_dr=38'h1.
- reset_n pulsed low at the 20th SDR bit -> all outputs at reset values the same cycle; no rsp_valid; the next command completes normally.
